// File: rtl/mem_ctrl_16x128.sv
// -----------------------------------------------------------------------------
// mem_ctrl_16x128
//
// Burst access controller in front of the CPU's 16x128 data RAM.
// It accepts single or burst read/write requests over a valid/ready handshake
// and sequences the RAM's one-cycle-latency, mutually exclusive read/write
// port. Read data comes back as a stream qualified by rdata_valid, with no
// backpressure.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_we          1 = write burst, 0 = read burst
//   req_addr        start word address
//   req_len         beats minus one (1..16 beats)
//   wdata_valid/ready, wdata   write beat stream (ready while writing)
//   rdata_valid, rdata         read beat stream, one cycle after each RAM read
//   busy            controller is not idle
//   ram_read_en, ram_write_en, ram_addr, ram_din, ram_dout   RAM port
// -----------------------------------------------------------------------------
module mem_ctrl_16x128 #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   cur_addr, cur_addr_d;
  logic [LEN_W-1:0]    beats_left, beats_left_d;
  logic                rd_pend;

  // State and burst bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
    end else begin
      state      <= state_d;
      cur_addr   <= cur_addr_d;
      beats_left <= beats_left_d;
    end
  end

  // The RAM output register is one cycle behind the read enable; rd_pend
  // tracks that beat so rdata_valid lines up with ram_dout. Reset clears it
  // asynchronously so an in-flight beat is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= ram_read_en;
    end
  end

  // Next-state and output decode. The RAM enables come only from the
  // current state, so read and write can never be asserted together.
  always_comb begin
    state_d      = state;
    cur_addr_d   = cur_addr;
    beats_left_d = beats_left;
    req_ready    = 1'b0;
    wdata_ready  = 1'b0;
    ram_read_en  = 1'b0;
    ram_write_en = 1'b0;

    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cur_addr_d   = req_addr;
          beats_left_d = req_len;
          state_d      = req_we ? WR : RD;
        end
      end

      RD: begin
        // One read issued every cycle; the address wraps 127 -> 0.
        ram_read_en  = 1'b1;
        cur_addr_d   = cur_addr + 1'b1;
        beats_left_d = beats_left - 1'b1;
        if (beats_left == '0) begin
          state_d = IDLE;
        end
      end

      WR: begin
        // Address and count only move on beats actually written; idle
        // cycles from the producer hold the burst in place.
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          ram_write_en = 1'b1;
          cur_addr_d   = cur_addr + 1'b1;
          beats_left_d = beats_left - 1'b1;
          if (beats_left == '0) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state != IDLE);
  assign ram_addr    = cur_addr;
  assign ram_din     = wdata;
  assign rdata_valid = rd_pend;
  assign rdata       = ram_dout;

endmodule

// File: tb/tb_mem_ctrl_16x128.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl_16x128
//
// Bench for mem_ctrl_16x128: a behavioural RAM hangs off the RAM port, a
// reference memory tracks what every accepted write beat should have stored,
// and each accepted read request pushes its expected words into a queue that
// a negedge monitor drains whenever rdata_valid is high.
// -----------------------------------------------------------------------------
module tb_mem_ctrl_16x128;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          ram_read_en;
  logic          ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  logic [DW-1:0] ram_mem [128];
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_word;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;

  always #5 clk = ~clk;

  mem_ctrl_16x128 #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy),
    .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM: registered read, write at the clock edge.
  always @(posedge clk) begin
    if (ram_write_en) begin
      ram_mem[ram_addr] <= ram_din;
      wr_count <= wr_count + 1;
    end
    if (ram_read_en) ram_dout <= ram_mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: drains expected read words, checks port exclusivity each cycle.
  always @(negedge clk) begin
    check("rd_wr_exclusive", 32'(ram_read_en & ram_write_en), 0);
    if (rst) begin
      exp_q.delete();
    end else if (rdata_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdata_unexpected actual=%0h required=none", rdata);
      end else begin
        exp_word = exp_q.pop_front();
        check("rdata", 32'(rdata), 32'(exp_word));
      end
    end
  end

  task automatic push_read(input logic [AW-1:0] a, input logic [LW-1:0] l);
    for (int i = 0; i <= int'(l); i++) exp_q.push_back(ref_mem[a + AW'(i)]);
  endtask

  // Present a request, wait for acceptance, then scramble the request fields
  // so any late sampling by the DUT would show up.
  task automatic accept(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int t = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_accept_timeout actual=0 required=1");
    end
    if (!we) push_read(a, l);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = AW'($urandom); req_len = LW'($urandom);
  endtask

  // Drive nbeats write beats; gaps come from pat (if patlen>0) or randomly.
  task automatic write_data(input logic [AW-1:0] a, input int nbeats, input logic [DW-1:0] base,
                            input int gap_pct, input logic [31:0] pat, input int patlen);
    int k = 0;
    int c = 0;
    logic v;
    while (k < nbeats && c < 500) begin
      if (patlen > 0) v = (c < patlen) ? pat[c] : 1'b1;
      else            v = ($urandom_range(99) >= gap_pct);
      wdata_valid = v;
      wdata = base + DW'(k);
      @(negedge clk);
      check("wdata_ready_in_wr", 32'(wdata_ready), 1);
      check("busy_in_wr", 32'(busy), 1);
      @(posedge clk); #1;
      if (v) begin
        ref_mem[a + AW'(k)] = base + DW'(k);
        k++;
      end
      c++;
    end
    if (k < nbeats) begin
      checks++; failures++;
      $display("FAIL write_timeout actual=%0d required=%0d", k, nbeats);
    end
    wdata_valid = 1'b0;
    wdata = DW'($urandom);
  endtask

  initial begin
    int wc0;
    logic          rw;
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    for (int i = 0; i < 128; i++) begin
      ram_mem[i] = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_wdata_ready", 32'(wdata_ready), 0);
    check("rst_rdata_valid", 32'(rdata_valid), 0);
    check("rst_ram_read_en", 32'(ram_read_en), 0);
    check("rst_ram_write_en", 32'(ram_write_en), 0);
    rst = 1'b0;

    // Single write then single read with exact latency
    accept(1'b1, 7'd5, 4'd0);
    write_data(7'd5, 1, 16'hA5A5, 0, 32'h1, 1);
    @(negedge clk);
    check("single_wr_busy_drop", 32'(busy), 0);
    @(posedge clk); #1;
    accept(1'b0, 7'd5, 4'd0);
    @(negedge clk);
    check("single_rd_c1_ready", 32'(req_ready), 0);
    check("single_rd_c1_rvalid", 32'(rdata_valid), 0);
    check("single_rd_c1_ren", 32'(ram_read_en), 1);
    @(negedge clk);
    check("single_rd_c2_ready", 32'(req_ready), 1);
    check("single_rd_c2_rvalid", 32'(rdata_valid), 1);
    check("single_rd_data", 32'(rdata), 32'h0000A5A5);

    // Wrapping 16-beat write then read back
    @(posedge clk); #1;
    accept(1'b1, 7'd120, 4'd15);
    write_data(7'd120, 16, 16'h0100, 0, 32'h0, 0);
    accept(1'b0, 7'd120, 4'd15);
    @(negedge clk);
    check("burst_rd_c1_rvalid", 32'(rdata_valid), 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("burst_rd_stream", 32'(rdata_valid), 1);
    end
    @(negedge clk);
    check("burst_rd_end_rvalid", 32'(rdata_valid), 0);

    // Gapped write: 4 beats with pattern 1,0,0,1,1,0,1
    @(posedge clk); #1;
    accept(1'b1, 7'd40, 4'd3);
    wc0 = wr_count;
    write_data(7'd40, 4, 16'h3000, 0, 32'b1011001, 7);
    @(negedge clk);
    check("gapped_busy_drop", 32'(busy), 0);
    check("gapped_write_count", 32'(wr_count - wc0), 4);
    @(posedge clk); #1;
    accept(1'b0, 7'd40, 4'd3);
    repeat (6) @(posedge clk);
    #1;

    // req_valid held high with changing fields during a burst
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd10; req_len = 4'd7;
    @(negedge clk);
    push_read(7'd10, 4'd7);
    @(posedge clk); #1;
    for (int t = 0; t < 50; t++) begin
      req_we = 1'($urandom); req_addr = AW'($urandom); req_len = LW'($urandom);
      @(negedge clk);
      if (req_ready) break;
      @(posedge clk); #1;
    end
    req_we = 1'b0; req_addr = 7'd77; req_len = 4'd2;
    push_read(7'd77, 4'd2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Reset in cycle 3 of a 16-beat read
    accept(1'b0, 7'd0, 4'd15);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_rdata_valid", 32'(rdata_valid), 0);
    check("midrst_ram_read_en", 32'(ram_read_en), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_req_ready", 32'(req_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    accept(1'b0, 7'd0, 4'd0);
    repeat (4) @(posedge clk);
    #1;

    // Randomized mix of bursts
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom);
      ra = AW'($urandom);
      rl = LW'($urandom);
      accept(rw, ra, rl);
      if (rw) write_data(ra, int'(rl) + 1, DW'($urandom), 30, 32'h0, 0);
    end

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
